// File: rtl/count_seg7_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the count_seg7_driver display stage:
//   - conv_state_t : conversion sequencer states (IDLE/LOAD/SHIFT/LATCH)
//   - NIBBLE_W     : width of one BCD digit
//   - GLYPH        : active-high segment patterns for 0-9, bit0=a ... bit6=g
//   - bcd_to_seg() : nibble -> segment pattern, blank for non-decimal nibbles
//   - pow10()      : elaboration helper used to size-check the digit count
// No ports (package).
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } conv_state_t;

  localparam int NIBBLE_W = 4;

  // Entry [0] is the rightmost element: GLYPH[d] is the pattern for digit d.
  localparam logic [9:0][6:0] GLYPH = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    seg = 7'h00;
    if (nibble <= 4'd9) seg = GLYPH[nibble];
    return seg;
  endfunction

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/count_seg7_driver_if.sv
// -----------------------------------------------------------------------------
// count_seg7_driver_if
// Bundles the counter-facing input and the display-facing outputs of the
// 7-segment driver.
//   count [bits-1:0]   binary value from the up/down counter
//   seg   [6:0]        segment drive, active-high, seg[0]=a ... seg[6]=g
//   an    [DIGITS-1:0] one-hot digit enable, an[0] = least significant digit
//   busy               high while a conversion is in progress
// Modports:
//   master : the display driver (drives seg/an/busy, reads count)
//   slave  : the surrounding system (drives count, observes the display)
// -----------------------------------------------------------------------------
interface count_seg7_driver_if #(
  parameter int bits   = 4,
  parameter int DIGITS = 2
);
  logic [bits-1:0]   count;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              busy;

  modport master (input count, output seg, output an, output busy);
  modport slave  (output count, input seg, input an, input busy);
endinterface

// File: rtl/count_seg7_driver_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: one add-3-then-shift step per clock.
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   start in   load bin and clear the BCD scratch on this edge
//   bin   in   BIN_W-bit binary operand
//   bcd   out  DIGITS*4-bit packed BCD result (scratch, valid when done=1)
//   done  out  high from the final shift until the next start/reset
// A conversion takes BIN_W shift edges after the start edge.
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int BIN_W  = 4,
  parameter int DIGITS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BIN_W-1:0]           bin,
  output logic [DIGITS*NIBBLE_W-1:0] bcd,
  output logic                       done
);

  localparam int BCD_W = DIGITS * NIBBLE_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [BCD_W-1:0] w_adj;

  // Any digit >= 5 would overflow past 9 when doubled, so pre-add 3.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[gi*NIBBLE_W +: NIBBLE_W] =
        (r_bcd[gi*NIBBLE_W +: NIBBLE_W] >= 4'd5) ?
        r_bcd[gi*NIBBLE_W +: NIBBLE_W] + 4'd3 :
        r_bcd[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (start) begin
      r_bin  <= bin;
      r_bcd  <= '0;
      r_cnt  <= CNT_W'(BIN_W);
      r_done <= 1'b0;
    end else if (r_cnt != '0) begin
      // Binary MSB shifts into the BCD LSB.
      {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
      r_cnt          <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_done <= 1'b1;
    end
  end

  assign bcd  = r_bcd;
  assign done = r_done;

endmodule

// File: rtl/count_seg7_driver.sv
// -----------------------------------------------------------------------------
// count_seg7_driver
// Snapshots the counter value, converts it to BCD and time-multiplexes the
// digits onto a shared 7-segment bus. Free-running; no handshake.
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   bus       master modport of count_seg7_driver_if (count in; seg/an/busy out)
// Parameters: bits (count width), DIGITS (BCD digits), SCAN_DIV (clocks/digit).
// Optional feature macro: LEADING_ZERO_BLANK_EN -- blanks digits above the most
// significant non-zero digit (digit 0 always shown); an still scans them.
// Conversion cycle: IDLE -> LOAD -> SHIFT x bits -> LATCH, bits+3 clocks.
// -----------------------------------------------------------------------------
module count_seg7_driver
  import seg7_pkg::*;
#(
  parameter int bits     = 4,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  count_seg7_driver_if.master bus
);

  localparam int DISP_W = DIGITS * NIBBLE_W;
  localparam int SCNT_W = (bits > 1) ? $clog2(bits) : 1;
  localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if (pow10(DIGITS) <= (2**bits) - 1) begin : g_bad_digits
      $error("count_seg7_driver: DIGITS too small for the count width");
    end
  endgenerate

  conv_state_t       r_state;
  logic [SCNT_W-1:0] r_shift_cnt;
  logic [DISP_W-1:0] r_disp;
  logic              r_busy;

  logic [PRE_W-1:0]  r_presc;
  logic [IDX_W-1:0]  r_idx;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;

  logic              w_start;
  logic              w_done;
  logic [DISP_W-1:0] w_bcd;
  logic [DIGITS-1:0] w_an;
  logic [DIGITS-1:0] w_blank;
  logic [3:0]        w_nibble;

  assign w_start = (r_state == LOAD);

  bin2bcd_seq #(
    .BIN_W  (bits),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .bin   (bus.count),
    .bcd   (w_bcd),
    .done  (w_done)
  );

  // Sequencer. The display register only changes in LATCH, so a reset or a
  // count change mid-conversion can never expose a partial value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift_cnt <= '0;
      r_disp      <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= LOAD;
          r_busy  <= 1'b1;
        end
        LOAD: begin
          r_state     <= SHIFT;
          r_shift_cnt <= '0;
          r_busy      <= 1'b1;
        end
        SHIFT: begin
          r_busy <= 1'b1;
          if (r_shift_cnt == SCNT_W'(bits - 1)) r_state <= LATCH;
          else r_shift_cnt <= r_shift_cnt + SCNT_W'(1);
        end
        LATCH: begin
          if (w_done) r_disp <= w_bcd;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
      assign w_an[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it are zero.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign w_blank[gi] = 1'b0;
      end else begin : g_upper
        assign w_blank[gi] = (r_disp[DISP_W-1:gi*NIBBLE_W] == '0);
      end
    end
  endgenerate
`else
  assign w_blank = '0;
`endif

  assign w_nibble = r_disp[r_idx*NIBBLE_W +: NIBBLE_W];

  // Scan: an/seg are registered from the current index, so the first edge
  // after reset shows digit 0 and the index advances once per prescaler wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= '0;
      r_seg   <= '0;
    end else begin
      if (r_presc == PRE_W'(SCAN_DIV - 1)) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_presc <= r_presc + PRE_W'(1);
      end
      r_an  <= w_an;
      r_seg <= w_blank[r_idx] ? 7'h00 : bcd_to_seg(w_nibble);
    end
  end

  assign bus.seg  = r_seg;
  assign bus.an   = r_an;
  assign bus.busy = r_busy;

endmodule
